// File: rtl/sc_io_pkg.sv
// Shared constants and address-decode helper for the memory-mapped IO port block.
package sc_io_pkg;

  localparam int unsigned OFF_OUT0     = 0;
  localparam int unsigned OFF_IN0      = 8;
  localparam int unsigned OFF_STAT     = 16;
  localparam int unsigned OFF_MASK     = 17;
  localparam int unsigned IO_SPACE_BIT = 7;
  localparam int unsigned MAX_PORTS    = 8;

  // IO space is the 128-byte window 0x80..0xFF.
  function automatic logic is_io(input logic [31:0] addr);
    return (addr[31:IO_SPACE_BIT+1] == '0) && addr[IO_SPACE_BIT];
  endfunction

endpackage

// File: rtl/sc_io_ports_if.sv
// CPU-side load/store bus between the core and the IO port block.
interface sc_io_ports_if #(
  parameter int unsigned DW = 32
);
  logic [31:0]   addr;
  logic [DW-1:0] wdata;
  logic          we;
  logic          io_sel;
  logic [DW-1:0] rdata;

  modport master (output addr, output wdata, output we, input io_sel, input rdata);
  modport slave  (input addr, input wdata, input we, output io_sel, output rdata);
endinterface

// File: rtl/sc_io_sync.sv
// Two-flop synchroniser for one input channel plus a change pulse on the synchronised value.
module sc_io_sync #(
  parameter int unsigned DW = 32
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] q_o,
  output logic          change_o
);
  logic [DW-1:0] meta_q, sync_q, prev_q;
  logic [2:0]    valid_q;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      meta_q  <= '0;
      sync_q  <= '0;
      prev_q  <= '0;
      valid_q <= '0;
    end else begin
      meta_q  <= d_i;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      valid_q <= {valid_q[1:0], 1'b1};
    end
  end

  // Suppress the pulse until prev_q holds a genuine post-reset sample.
  assign q_o      = sync_q;
  assign change_o = valid_q[2] && (sync_q != prev_q);

endmodule

// File: rtl/sc_io_ports.sv
// Memory-mapped output registers, synchronised input ports, sticky change flags and interrupt.
module sc_io_ports #(
  parameter int unsigned N_OUT = 3,
  parameter int unsigned N_IN  = 2,
  parameter int unsigned DW    = 32
) (
  input  logic                  clock,
  input  logic                  resetn,
  sc_io_ports_if.slave          bus,
  output logic [N_OUT*DW-1:0]   out_port,
  input  logic [N_IN*DW-1:0]    in_port,
  output logic                  irq
);
  import sc_io_pkg::*;

  logic [31:0]                off;
  logic                       wr;
  logic [DW-1:0]              rd;
  logic [N_OUT-1:0][DW-1:0]   out_q, out_d;
  logic [N_IN-1:0][DW-1:0]    in_sync;
  logic [N_IN-1:0]            chg;
  logic [N_IN-1:0]            stat_q, stat_d;
  logic [N_IN-1:0]            mask_q, mask_d;
  logic                       irq_q;
  logic                       unused_addr;

  assign bus.io_sel  = is_io(bus.addr);
  assign off         = {27'd0, bus.addr[6:2]};
  assign wr          = bus.we & bus.io_sel;
  assign unused_addr = ^bus.addr[1:0];

  for (genvar k = 0; k < N_IN; k++) begin : g_sync
    sc_io_sync #(
      .DW(DW)
    ) u_sync (
      .clock    (clock),
      .resetn   (resetn),
      .d_i      (in_port[k*DW +: DW]),
      .q_o      (in_sync[k]),
      .change_o (chg[k])
    );
  end

  always_comb begin
    out_d = out_q;
    for (int unsigned k = 0; k < N_OUT; k++) begin
      if (wr && off == OFF_OUT0 + k) out_d[k] = bus.wdata;
    end

    stat_d = stat_q;
    if (wr && off == OFF_STAT) stat_d = stat_q & ~bus.wdata[N_IN-1:0];
    // A fresh change overrides a same-cycle clear.
    stat_d = stat_d | chg;

    mask_d = mask_q;
    if (wr && off == OFF_MASK) mask_d = bus.wdata[N_IN-1:0];
  end

  always_comb begin
    rd = '0;
    if (bus.io_sel) begin
      for (int unsigned k = 0; k < N_OUT; k++) begin
        if (off == OFF_OUT0 + k) rd = out_q[k];
      end
      for (int unsigned k = 0; k < N_IN; k++) begin
        if (off == OFF_IN0 + k) rd = in_sync[k];
      end
      if (off == OFF_STAT) rd[N_IN-1:0] = stat_q;
      if (off == OFF_MASK) rd[N_IN-1:0] = mask_q;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      out_q  <= '0;
      stat_q <= '0;
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      stat_q <= stat_d;
      mask_q <= mask_d;
      irq_q  <= |(stat_q & mask_q);
    end
  end

  assign bus.rdata = rd;
  assign out_port  = out_q;
  assign irq       = irq_q;

endmodule

// File: doc/sc_io_ports.md
SC_IO_PORTS -- requirements
Module: sc_io_ports

Interface
REQ-001 The block SHALL take parameter N_OUT, default 3: number of memory-mapped output ports, legal 1..8.
REQ-002 The block SHALL take parameter N_IN, default 2: number of input ports, legal 1..8.
REQ-003 The block SHALL take parameter DW, default 32: port and data-bus width.
REQ-004 The block SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port resetn, input, 1 bit: synchronous, active-low reset.
REQ-006 The block SHALL have port addr, input, 32 bits: byte address from the CPU ALU result.
REQ-007 The block SHALL have port wdata, input, DW bits: store data.
REQ-008 The block SHALL have port we, input, 1 bit: store strobe, one access per cycle.
REQ-009 The block SHALL have port io_sel, output, 1 bit: combinational; addr lies in IO space, so data memory must ignore the access.
REQ-010 The block SHALL have port rdata, output, DW bits: combinational read data, valid whenever io_sel=1.
REQ-011 The block SHALL have port out_port, output, N_OUT*DW bits: port k occupies slice [k*DW +: DW].
REQ-012 The block SHALL have port in_port, input, N_IN*DW bits: asynchronous board inputs, same slicing.
REQ-013 The block SHALL have port irq, output, 1 bit: registered interrupt request.

Function
REQ-014 io_sel SHALL be 1 iff addr[31:8]==0 and addr[7]==1; word offset off = addr[6:2]; addr[1:0] ignored.
REQ-015 Offsets 0..N_OUT-1 (OUT_k) SHALL be read/write output registers driving out_port directly.
REQ-016 A store with we=1, io_sel=1 to OUT_k SHALL make out_port slice k equal wdata from the next edge (latency 1).
REQ-017 Offsets 8..8+N_IN-1 (IN_k) SHALL be read-only and return the synchronised input value.
REQ-018 Each in_port slice SHALL pass through a 2-flop synchroniser; a change SHALL be visible on IN_k reads 2 edges after it is applied.
REQ-019 Offset 16 (STAT) bit k SHALL be a sticky flag, set on the edge at which synchronised IN_k differs from its previous-cycle value.
REQ-020 Writing STAT SHALL be write-1-to-clear per bit; if set and clear occur in the same cycle, set SHALL win.
REQ-021 Offset 17 (MASK) SHALL be a read/write interrupt enable register; bits above N_IN SHALL read 0 and ignore writes.
REQ-022 irq SHALL be registered as |(STAT & MASK) of the current cycle, i.e. one edge after the flag or mask change.
REQ-023 Reads of unused or unimplemented offsets SHALL return 0, and writes to them SHALL have no effect.
REQ-024 When io_sel=0, rdata SHALL be 0 and no register SHALL change.
REQ-025 Stores while io_sel=0 SHALL be ignored regardless of we.

Reset
REQ-026 With resetn=0 at an edge, all OUT_k, STAT, MASK, and synchroniser and previous-value flops SHALL clear to 0, and irq SHALL be 0.
REQ-027 Reset SHALL override a simultaneous store, and no change flag SHALL be raised by the first input samples after reset release.
REQ-028 Reset asserted mid-operation SHALL drop irq and clear out_port on that same edge.

Structure
REQ-029 Package sc_io_pkg SHALL hold the offset constants OFF_OUT0=0, OFF_IN0=8, OFF_STAT=16, OFF_MASK=17, and IO_SPACE_BIT=7.
REQ-030 Sub-module sc_io_sync SHALL provide the per-channel 2-flop synchroniser plus change pulse, instantiated N_IN times via generate.
REQ-031 Address decode, the register file, and the read mux SHALL live in sc_io_ports; target size is 150-300 lines of RTL.

Verification
REQ-032 Reset then store 0x0000_00A5 to addr 0x84 (OUT_1) -> out_port slice 1 = 0xA5 after 1 edge; slices 0 and 2 remain 0.
REQ-033 Set in_port slice 0 to 0x1234 -> IN_0 (addr 0xA0) reads 0x1234 at edge 2; STAT bit0 = 1 on the following edge.
REQ-034 MASK=0x1, toggle input 0 -> irq rises 1 edge after STAT bit0; store 0x1 to STAT (0xC0) -> bit0 and irq clear.
REQ-035 W1C of STAT bit0 in the same cycle as a new change on input 0 -> bit0 stays 1 and irq stays high.
REQ-036 Read addr 0x40 (io_sel=0) and addr 0xFC (unused offset) -> rdata = 0; store to 0x40 leaves all IO state unchanged.
REQ-037 Assert resetn=0 with irq high and OUT_0 = 0xFFFF_FFFF -> on the next edge irq = 0, out_port = 0, MASK = 0.
